stopwatch_core: RTL and testbench

Time-keeping and control stage of the stop-watch design: consumes single-cycle key-press pulses from the debounce/edge-detect stage and produces four registered BCD digits (M:SS.s) for the seven-segment digit multiplexer. It owns the 1/10 s prescaler, a cascaded BCD counter, and a run/stop/lap state machine.

---
 rtl/stopwatch_pkg.sv | 34 +++
 rtl/bcd_digit_counter.sv | 42 ++++
 rtl/stopwatch_core.sv | 211 +++++++++++++++++++++
 tb/tb_stopwatch_core.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared types and digit limits for the stop-watch core.
// Optional lap feature is selected in stopwatch_core by STOPWATCH_LAP_EN.
package stopwatch_pkg;

    // Control states; LAP is only reachable when STOPWATCH_LAP_EN is defined.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        LAP     = 2'd2,
        STOPPED = 2'd3
    } state_t;

    typedef logic [3:0] bcd_t;

    // Inclusive upper value of each display digit (M:SS.s).
    localparam bcd_t SUBSEC_MAX  = 4'd9;
    localparam bcd_t SEC_MAX     = 4'd9;
    localparam bcd_t TEN_SEC_MAX = 4'd5;
    localparam bcd_t MIN_MAX     = 4'd9;

    // Full display value, most significant digit first.
    typedef struct packed {
        bcd_t min;
        bcd_t ten_sec;
        bcd_t sec;
        bcd_t subsec;
    } bcd_time_t;

    // The prescaler and the counters only advance in these states.
    function automatic logic is_counting(input state_t s);
        return (s == RUNNING) || (s == LAP);
    endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// bcd_digit_counter: one decimal digit of the cascaded time counter.
// Counts 0..MAX on inc, synchronous clear has priority, carry is combinational.
module bcd_digit_counter
    import stopwatch_pkg::*;
#(
    parameter bcd_t MAX = 4'd9
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic inc,
    output bcd_t value,
    output logic carry
);

    bcd_t value_q;
    bcd_t value_d;

    // Next digit value: clear, else step and roll over past MAX.
    always_comb begin
        value_d = value_q;
        if (clear) begin
            value_d = '0;
        end else if (inc) begin
            // >= keeps the digit in range even from an unexpected value
            value_d = (value_q >= MAX) ? '0 : value_q + 4'd1;
        end
    end

    // Digit register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;
    assign carry = inc && (value_q == MAX);

endmodule

// File: rtl/stopwatch_core.sv
// stopwatch_core: 1/10 s prescaler, cascaded BCD time counter and the
// run/stop/lap control FSM of the stop-watch.
// Build option: define STOPWATCH_LAP_EN to include the LAP state and the
// snapshot latch; without it lap_hold is 0 and the display is always live.
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int unsigned CLOCK_HZ = 12_000_000,
    parameter int unsigned TICK_HZ  = 10
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start_stop,
    input  logic       lap_reset,
    output logic       running,
    output logic       lap_hold,
    output logic [3:0] digit_min,
    output logic [3:0] digit_ten_sec,
    output logic [3:0] digit_sec,
    output logic [3:0] digit_subsec,
    output logic       wrap
);

    localparam int unsigned DIV = CLOCK_HZ / TICK_HZ;
    localparam int unsigned PW  = $clog2(DIV);
    localparam logic [PW-1:0] PRESC_TOP = PW'(DIV - 1);

    state_t state_q;
    state_t state_d;

    logic          presc_clear;
    logic          cnt_clear;
    logic          snap_load;
    logic          counting;
    logic          tick;
    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic          wrap_q;
    logic          wrap_d;

    bcd_time_t live;
    bcd_time_t disp;
    logic      carry_subsec;
    logic      carry_sec;
    logic      carry_ten_sec;
    logic      carry_min;

    // Control FSM: next state plus the one-cycle clear/load strobes.
    // start_stop is tested first in every state so it wins over lap_reset.
    always_comb begin
        state_d     = state_q;
        presc_clear = 1'b0;
        cnt_clear   = 1'b0;
        snap_load   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_stop) begin
                    state_d     = RUNNING;
                    presc_clear = 1'b1;
                end
            end
            RUNNING: begin
                if (start_stop) begin
                    state_d = STOPPED;
                end
`ifdef STOPWATCH_LAP_EN
                else if (lap_reset) begin
                    state_d   = LAP;
                    snap_load = 1'b1;
                end
`endif
            end
`ifdef STOPWATCH_LAP_EN
            LAP: begin
                if (start_stop) begin
                    state_d = STOPPED;
                end else if (lap_reset) begin
                    state_d = RUNNING;
                end
            end
`endif
            STOPPED: begin
                // Resume keeps the prescaler phase; only a clear zeroes it.
                if (start_stop) begin
                    state_d = RUNNING;
                end else if (lap_reset) begin
                    state_d     = IDLE;
                    presc_clear = 1'b1;
                    cnt_clear   = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign counting = is_counting(state_q);

    // Prescaler next value and the one-cycle count tick at its top value.
    always_comb begin
        tick    = counting && (presc_q == PRESC_TOP);
        presc_d = presc_q;
        if (presc_clear) begin
            presc_d = '0;
        end else if (counting) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
        end
    end

    // Prescaler register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    bcd_digit_counter #(.MAX(SUBSEC_MAX)) u_subsec (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (cnt_clear),
        .inc     (tick),
        .value   (live.subsec),
        .carry   (carry_subsec)
    );

    bcd_digit_counter #(.MAX(SEC_MAX)) u_sec (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (cnt_clear),
        .inc     (carry_subsec),
        .value   (live.sec),
        .carry   (carry_sec)
    );

    bcd_digit_counter #(.MAX(TEN_SEC_MAX)) u_ten_sec (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (cnt_clear),
        .inc     (carry_sec),
        .value   (live.ten_sec),
        .carry   (carry_ten_sec)
    );

    bcd_digit_counter #(.MAX(MIN_MAX)) u_min (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (cnt_clear),
        .inc     (carry_ten_sec),
        .value   (live.min),
        .carry   (carry_min)
    );

    assign wrap_d = carry_min;

    // Wrap pulse lands in the same cycle as the 0:00.0 digits.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

`ifdef STOPWATCH_LAP_EN
    bcd_time_t snap_q;
    bcd_time_t snap_d;

    // Snapshot takes the pre-edge live count, so a coinciding tick is excluded.
    always_comb begin
        snap_d = snap_q;
        if (snap_load) begin
            snap_d = live;
        end
    end

    // Lap snapshot register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            snap_q <= '0;
        end else begin
            snap_q <= snap_d;
        end
    end

    assign lap_hold = (state_q == LAP);
    assign disp     = lap_hold ? snap_q : live;
`else
    assign lap_hold = 1'b0;
    assign disp     = live;
`endif

    assign running       = counting;
    assign wrap          = wrap_q;
    assign digit_min     = disp.min;
    assign digit_ten_sec = disp.ten_sec;
    assign digit_sec     = disp.sec;
    assign digit_subsec  = disp.subsec;

endmodule

// File: tb/tb_stopwatch_core.sv
// tb_stopwatch_core: table-driven bench for stopwatch_core at 10 cycles/tick.
// Lap sequences follow STOPWATCH_LAP_EN.
module tb_stopwatch_core;

    logic       clock      = 1'b0;
    logic       reset_n    = 1'b0;
    logic       start_stop = 1'b0;
    logic       lap_reset  = 1'b0;
    logic       running;
    logic       lap_hold;
    logic [3:0] digit_min;
    logic [3:0] digit_ten_sec;
    logic [3:0] digit_sec;
    logic [3:0] digit_subsec;
    logic       wrap;

    stopwatch_core #(
        .CLOCK_HZ (100),
        .TICK_HZ  (10)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .start_stop    (start_stop),
        .lap_reset     (lap_reset),
        .running       (running),
        .lap_hold      (lap_hold),
        .digit_min     (digit_min),
        .digit_ten_sec (digit_ten_sec),
        .digit_sec     (digit_sec),
        .digit_subsec  (digit_subsec),
        .wrap          (wrap)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          id;
        logic [15:0] dig;
        logic        run;
        logic        hold;
        logic        wrp;
    } exp_t;

    typedef struct {
        logic        ss;
        logic        lr;
        int unsigned w;
        logic [15:0] dig;
        logic        run;
        logic        hold;
        logic        wrp;
    } vec_t;

    exp_t        sb_q[$];
    vec_t        vecs[22];
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic cmp(input int id, input string what, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL step%0d %s: got %h expected %h", id, what, act, exp);
        end
    endtask

    task automatic push_exp(input int id, input logic [15:0] dig, input logic run,
                            input logic hold, input logic wrp);
        exp_t e;
        e.id   = id;
        e.dig  = dig;
        e.run  = run;
        e.hold = hold;
        e.wrp  = wrp;
        sb_q.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard: got empty queue expected an entry");
            return;
        end
        e = sb_q.pop_front();
        cmp(e.id, "digits", {digit_min, digit_ten_sec, digit_sec, digit_subsec}, e.dig);
        cmp(e.id, "running", {15'd0, running}, {15'd0, e.run});
        cmp(e.id, "lap_hold", {15'd0, lap_hold}, {15'd0, e.hold});
        cmp(e.id, "wrap", {15'd0, wrap}, {15'd0, e.wrp});
    endtask

    // Called at a negedge: optional one-edge press, w more cycles, then compare.
    task automatic step(input int id, input logic ss, input logic lr, input int unsigned w,
                        input logic [15:0] dig, input logic run, input logic hold, input logic wrp);
        push_exp(id, dig, run, hold, wrp);
        if (ss || lr) begin
            start_stop = ss;
            lap_reset  = lr;
            @(negedge clock);
            start_stop = 1'b0;
            lap_reset  = 1'b0;
        end
        repeat (w) @(negedge clock);
        pop_check();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got time limit expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //          ss    lr    wait  digits    run   hold  wrap
        vecs[0]  = '{1'b0, 1'b1, 5,   16'h0000, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 0,   16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 9,   16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1,   16'h0001, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 140, 16'h0015, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 0,   16'h0015, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 50,  16'h0015, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 0,   16'h0015, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 8,   16'h0015, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1,   16'h0016, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 0,   16'h0016, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 0,   16'h0000, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 20,  16'h0000, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 0,   16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 9,   16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 1,   16'h0001, 1'b1, 1'b0, 1'b0};
        vecs[16] = '{1'b1, 1'b1, 0,   16'h0001, 1'b0, 1'b0, 1'b0};
        vecs[17] = '{1'b0, 1'b0, 15,  16'h0001, 1'b0, 1'b0, 1'b0};
        vecs[18] = '{1'b1, 1'b0, 0,   16'h0001, 1'b1, 1'b0, 1'b0};
        vecs[19] = '{1'b0, 1'b0, 9,   16'h0002, 1'b1, 1'b0, 1'b0};
        vecs[20] = '{1'b1, 1'b0, 0,   16'h0002, 1'b0, 1'b0, 1'b0};
        vecs[21] = '{1'b0, 1'b1, 0,   16'h0000, 1'b0, 1'b0, 1'b0};

        // Reset state while reset is held.
        repeat (3) @(negedge clock);
        push_exp(-1, 16'h0000, 1'b0, 1'b0, 1'b0);
        pop_check();
        reset_n = 1'b1;

        // Start/count, stop/hold, resume with retained phase, clear, simultaneous pulses.
        for (int i = 0; i < 22; i++) begin
            step(i, vecs[i].ss, vecs[i].lr, vecs[i].w, vecs[i].dig,
                 vecs[i].run, vecs[i].hold, vecs[i].wrp);
        end

`ifdef STOPWATCH_LAP_EN
        // Lap capture at 0:02.0, frozen for 30 cycles, release shows 0:02.3.
        step(100, 1'b1, 1'b0, 0,   16'h0000, 1'b1, 1'b0, 1'b0);
        step(101, 1'b0, 1'b0, 200, 16'h0020, 1'b1, 1'b0, 1'b0);
        step(102, 1'b0, 1'b1, 0,   16'h0020, 1'b1, 1'b1, 1'b0);
        step(103, 1'b0, 1'b0, 29,  16'h0020, 1'b1, 1'b1, 1'b0);
        step(104, 1'b0, 1'b1, 0,   16'h0023, 1'b1, 1'b0, 1'b0);
        step(105, 1'b0, 1'b0, 8,   16'h0023, 1'b1, 1'b0, 1'b0);
        // Capture on a tick edge: snapshot 0:02.3, live moves to 0:02.4.
        step(106, 1'b0, 1'b1, 0,   16'h0023, 1'b1, 1'b1, 1'b0);
        step(107, 1'b1, 1'b0, 0,   16'h0024, 1'b0, 1'b0, 1'b0);
        step(108, 1'b0, 1'b1, 0,   16'h0000, 1'b0, 1'b0, 1'b0);
`else
        // lap_reset while running is ignored without the lap feature.
        step(100, 1'b1, 1'b0, 0,   16'h0000, 1'b1, 1'b0, 1'b0);
        step(101, 1'b0, 1'b0, 200, 16'h0020, 1'b1, 1'b0, 1'b0);
        step(102, 1'b0, 1'b1, 0,   16'h0020, 1'b1, 1'b0, 1'b0);
        step(103, 1'b0, 1'b0, 29,  16'h0023, 1'b1, 1'b0, 1'b0);
        step(104, 1'b1, 1'b0, 0,   16'h0023, 1'b0, 1'b0, 1'b0);
        step(105, 1'b0, 1'b1, 0,   16'h0000, 1'b0, 1'b0, 1'b0);
`endif

        // Minute carry, run to 9:59.9, wrap pulse, continue counting.
        step(200, 1'b1, 1'b0, 0,     16'h0000, 1'b1, 1'b0, 1'b0);
        step(201, 1'b0, 1'b0, 5990,  16'h0599, 1'b1, 1'b0, 1'b0);
        step(202, 1'b0, 1'b0, 10,    16'h1000, 1'b1, 1'b0, 1'b0);
        step(203, 1'b0, 1'b0, 53990, 16'h9599, 1'b1, 1'b0, 1'b0);
        step(204, 1'b0, 1'b0, 9,     16'h9599, 1'b1, 1'b0, 1'b0);
        step(205, 1'b0, 1'b0, 1,     16'h0000, 1'b1, 1'b0, 1'b1);
        step(206, 1'b0, 1'b0, 1,     16'h0000, 1'b1, 1'b0, 1'b0);
        step(207, 1'b0, 1'b0, 9,     16'h0001, 1'b1, 1'b0, 1'b0);
        step(208, 1'b0, 1'b0, 60,    16'h0007, 1'b1, 1'b0, 1'b0);
        step(209, 1'b0, 1'b0, 4,     16'h0007, 1'b1, 1'b0, 1'b0);

        // Mid-count reset: clears at once, held 3 cycles.
        reset_n = 1'b0;
        #1;
        push_exp(300, 16'h0000, 1'b0, 1'b0, 1'b0);
        pop_check();
        repeat (3) @(negedge clock);
        push_exp(301, 16'h0000, 1'b0, 1'b0, 1'b0);
        pop_check();
        reset_n = 1'b1;

        // No leftover prescaler phase: first tick a full 10 cycles after start.
        step(302, 1'b0, 1'b0, 5, 16'h0000, 1'b0, 1'b0, 1'b0);
        step(303, 1'b1, 1'b0, 0, 16'h0000, 1'b1, 1'b0, 1'b0);
        step(304, 1'b0, 1'b0, 9, 16'h0000, 1'b1, 1'b0, 1'b0);
        step(305, 1'b0, 1'b0, 1, 16'h0001, 1'b1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
